alu_pkt_engine: RTL and testbench

//  Parametrised packet ALU. Accepts a header word (cmd_in=1) followed by N operand words.

---
 rtl/alu_pkt_engine_if.sv | 12 +
 rtl/alu_pkt_engine.sv | 191 +++++++++++++++++++
 tb/tb_alu_pkt_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkt_engine_if.sv
// Valid/ready word stream used on both the request and response side of alu_pkt_engine.
interface alu_pkt_engine_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] data;   // header, operand or result word
    logic              valid;  // data is valid this cycle
    logic              cmd;    // 1 = header word, 0 = operand/result word
    logic              ready;  // sink accepts the word this cycle

    modport master (output data, valid, cmd, input  ready);
    modport slave  (input  data, valid, cmd, output ready);
endinterface

// File: rtl/alu_pkt_engine.sv
// Packet ALU: takes a header plus n operands, folds the operands with the header
// opcode and answers with a two-word response (header, then result). Counts words
// that arrive when they cannot be used and packets cut short by an early header.
module alu_pkt_engine #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_pkt_engine_if.slave  pkt_in,
    alu_pkt_engine_if.master pkt_out,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MIN = 4'd7;
    localparam logic [3:0] OP_MAX = 4'd8;

    // Shift amounts at or beyond the word width flush the operand to zero.
    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_COMPUTE,
        S_SEND_HDR,
        S_SEND_RES
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [4:0]        tag_q, tag_d;
    logic [5:0]        n_q, n_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              cmd_q, cmd_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  abort_q, abort_d;
    logic              accept;
    logic              drop_inc;
    logic              abort_inc;
    logic              err;

    // One fold step: combine the running accumulator with the next operand.
    function automatic logic [DATA_W-1:0] fold(input logic [3:0]        op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SHL:  return (b >= SHIFT_LIM) ? '0 : (a << b);
            OP_SHR:  return (b >= SHIFT_LIM) ? '0 : (a >> b);
            OP_MIN:  return (b < a) ? b : a;
            OP_MAX:  return (b > a) ? b : a;
            default: return a;
        endcase
    endfunction

    // Packet FSM: next state, accumulator, response words and counter updates.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        drop_d    = drop_q;
        abort_d   = abort_q;
        abort_inc = 1'b0;
        err       = 1'b0;
        accept    = pkt_in.valid && ready_q;
        drop_inc  = pkt_in.valid && !ready_q;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (accept && pkt_in.cmd) begin
                    // A header mid-packet throws away the partial packet and starts over.
                    abort_inc = (state_q == S_COLLECT);
                    op_d      = pkt_in.data[15:12];
                    tag_d     = pkt_in.data[10:6];
                    n_d       = pkt_in.data[5:0];
                    cnt_d     = '0;
                    acc_d     = '0;
                    state_d   = (pkt_in.data[5:0] == 6'd0) ? S_COMPUTE : S_COLLECT;
                end else if (accept && state_q == S_IDLE) begin
                    drop_inc = 1'b1;
                end else if (accept) begin
                    acc_d = (cnt_q == 6'd0) ? pkt_in.data : fold(op_q, acc_q, pkt_in.data);
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == n_q) begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                err = (op_q > OP_MAX) || (n_q == 6'd0) ||
                      (op_q == OP_NOT && n_q != 6'd1) ||
                      ((op_q == OP_SHL || op_q == OP_SHR) && n_q != 6'd2);
                if (err) begin
                    acc_d = '0;
                end else if (op_q == OP_NOT) begin
                    acc_d = ~acc_q;
                end
                data_d        = '0;
                data_d[15:0]  = {op_q, err, tag_q, 6'd1};
                valid_d       = 1'b1;
                cmd_d         = 1'b1;
                state_d       = S_SEND_HDR;
            end
            S_SEND_HDR: begin
                if (pkt_out.ready) begin
                    data_d  = acc_q;
                    cmd_d   = 1'b0;
                    state_d = S_SEND_RES;
                end
            end
            S_SEND_RES: begin
                if (pkt_out.ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);

        if (drop_inc && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
        if (abort_inc && abort_q != '1) begin
            abort_d = abort_q + 1'b1;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values from before the edge.
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cmd_q   <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
        end
    end

    assign pkt_in.ready  = ready_q;
    assign pkt_out.data  = data_q;
    assign pkt_out.valid = valid_q;
    assign pkt_out.cmd   = cmd_q;
    assign drop_cnt      = drop_q;
    assign abort_cnt     = abort_q;

endmodule

// File: tb/tb_alu_pkt_engine.sv
// Bench for alu_pkt_engine: a 16-bit and a 32-bit instance share one input stream and
// one out_ready; each response is checked against a packet-level reference model.
module tb_alu_pkt_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] din = '0;
    logic        out_ready = 1'b1;
    logic [15:0] drop16, abort16, drop32, abort32;

    always #5 clk = ~clk;

    alu_pkt_engine_if #(.DATA_W(16)) in16 ();
    alu_pkt_engine_if #(.DATA_W(16)) out16 ();
    alu_pkt_engine_if #(.DATA_W(32)) in32 ();
    alu_pkt_engine_if #(.DATA_W(32)) out32 ();

    assign in16.valid  = vin;
    assign in16.cmd    = cin;
    assign in16.data   = din[15:0];
    assign out16.ready = out_ready;
    assign in32.valid  = vin;
    assign in32.cmd    = cin;
    assign in32.data   = din;
    assign out32.ready = out_ready;

    alu_pkt_engine #(.DATA_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .pkt_in(in16.slave), .pkt_out(out16.master),
        .drop_cnt(drop16), .abort_cnt(abort16)
    );
    alu_pkt_engine #(.DATA_W(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst(rst), .pkt_in(in32.slave), .pkt_out(out32.master),
        .drop_cnt(drop32), .abort_cnt(abort32)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          bp_mode  = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
    int          acc_cyc  = 0;
    logic [32:0] q16[$];
    logic [32:0] q32[$];
    logic [31:0] last_hdr[2];
    logic [31:0] last_res[2];
    int          hdr_cyc[2];
    int          res_cyc[2];
    bit          hold_pend[2];
    logic [31:0] hold_data[2];
    bit          pkt_open = 1'b0;
    logic [3:0]  p_op;
    logic [4:0]  p_tag;
    int          p_n;
    logic [31:0] p_ops[$];
    int          exp_drop  = 0;
    int          exp_abort = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-packet reduction for a given word width.
    task automatic ref_pkt(input int w, input logic [3:0] op, input int n,
                           input logic [31:0] ops[$], output logic [31:0] res, output bit err);
        logic [31:0]     mask;
        longint unsigned sum;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        err  = (op > 8) || (n == 0) || (op == 4 && n != 1) || ((op == 5 || op == 6) && n != 2);
        res  = '0;
        if (!err) begin
            res = ops[0] & mask;
            case (op)
                0: begin
                    sum = 0;
                    foreach (ops[i]) sum += ops[i] & mask;
                    res = 32'(sum) & mask;
                end
                1: for (int i = 1; i < ops.size(); i++) res = res & ops[i];
                2: for (int i = 1; i < ops.size(); i++) res = res | (ops[i] & mask);
                3: for (int i = 1; i < ops.size(); i++) res = res ^ (ops[i] & mask);
                4: res = ~ops[0] & mask;
                5: res = ((ops[1] & mask) >= 32'(w)) ? '0 : (ops[0] << (ops[1] & mask)) & mask;
                6: res = ((ops[1] & mask) >= 32'(w)) ? '0 : (ops[0] & mask) >> (ops[1] & mask);
                7: for (int i = 1; i < ops.size(); i++) if ((ops[i] & mask) < res) res = ops[i] & mask;
                8: for (int i = 1; i < ops.size(); i++) if ((ops[i] & mask) > res) res = ops[i] & mask;
                default: res = '0;
            endcase
        end
    endtask

    task automatic finish_pkt();
        logic [31:0] r;
        bit          e;
        ref_pkt(16, p_op, p_n, p_ops, r, e);
        q16.push_back({1'b1, 16'h0, p_op, e, p_tag, 6'd1});
        q16.push_back({1'b0, r});
        ref_pkt(32, p_op, p_n, p_ops, r, e);
        q32.push_back({1'b1, 16'h0, p_op, e, p_tag, 6'd1});
        q32.push_back({1'b0, r});
        pkt_open = 1'b0;
    endtask

    // Present one word once the engine is ready; returns just after the accepting edge.
    task automatic put(input logic [31:0] d, input bit c);
        int b = 0;
        forever begin
            @(negedge clk);
            if (in16.ready || b >= 200) break;
            b++;
        end
        if (!in16.ready) begin
            check("in_ready_wait", in16.ready, 1);
            return;
        end
        vin = 1'b1;
        din = d;
        cin = c;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        vin = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] w);
        put(w, 1'b1);
        if (pkt_open) exp_abort++;
        p_op  = w[15:12];
        p_tag = w[10:6];
        p_n   = int'(w[5:0]);
        p_ops.delete();
        pkt_open = 1'b1;
        if (p_n == 0) finish_pkt();
    endtask

    task automatic send_op(input logic [31:0] d);
        put(d, 1'b0);
        if (!pkt_open) begin
            exp_drop++;
        end else begin
            p_ops.push_back(d);
            if (p_ops.size() == p_n) finish_pkt();
        end
    endtask

    task automatic drain();
        int b = 0;
        while ((q16.size() != 0 || q32.size() != 0 || !in16.ready) && b < 400) begin
            @(negedge clk);
            b++;
        end
        check("drain_q16", q16.size(), 0);
        check("drain_q32", q32.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q16.delete();
        q32.delete();
        pkt_open  = 1'b0;
        exp_drop  = 0;
        exp_abort = 0;
        @(negedge clk);
        check("rst_data16", out16.data, 0);
        check("rst_data32", out32.data, 0);
        check("rst_valid", {out16.valid, out32.valid}, 0);
        check("rst_cmd", {out16.cmd, out32.cmd}, 0);
        check("rst_in_ready", {in16.ready, in32.ready}, 0);
        check("rst_drop", {drop16, drop32}, 0);
        check("rst_abort", {abort16, abort32}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {in16.ready, in32.ready}, 2'b11);
    endtask

    // Output monitor step for one instance: stability under backpressure and scoreboard on transfer.
    task automatic mon(input int i, input logic v, input logic c, input logic r, input logic [31:0] d);
        logic [32:0] e;
        if (v && hold_pend[i]) check(i == 0 ? "hold16" : "hold32", d, hold_data[i]);
        hold_pend[i] = 1'b0;
        if (v && r) begin
            if ((i == 0 && q16.size() == 0) || (i == 1 && q32.size() == 0)) begin
                check(i == 0 ? "unexpected_out16" : "unexpected_out32", v, 0);
            end else begin
                e = (i == 0) ? q16.pop_front() : q32.pop_front();
                check(i == 0 ? "out16" : "out32", {c, d}, e);
            end
            if (c) begin
                last_hdr[i] = d;
                hdr_cyc[i]  = cyc;
            end else begin
                last_res[i] = d;
                res_cyc[i]  = cyc;
            end
        end else if (v) begin
            hold_pend[i] = 1'b1;
            hold_data[i] = d;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        mon(0, out16.valid, out16.cmd, out_ready, {16'h0, out16.data});
        mon(1, out32.valid, out32.cmd, out_ready, out32.data);
    end

    initial begin
        int k;
        int b;
        int op;
        int n;
        int nops;
        logic [31:0] opnd;

        do_reset();

        // Test 1: ADD with carry wrap, latency of header, result and next ready.
        send_hdr(32'h0003);
        send_op(32'hFFFF);
        send_op(32'h0002);
        send_op(32'h0010);
        k = acc_cyc;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!in16.ready && b < 20);
        check("t1_ready_cyc", cyc, k + 3);
        check("t1_hdr_cyc", hdr_cyc[0], k + 1);
        check("t1_res_cyc", res_cyc[0], k + 2);
        check("t1_hdr", last_hdr[0], 32'h0001);
        check("t1_res16", last_res[0], 32'h0011);
        check("t1_res32", last_res[1], 32'h0001_0011);

        // Test 2: NOT, then NOT with a bad count.
        send_hdr(32'h4001);
        send_op(32'h00F0);
        drain();
        check("t2_not_hdr", last_hdr[0], 32'h4001);
        check("t2_not_res16", last_res[0], 32'hFF0F);
        check("t2_not_res32", last_res[1], 32'hFFFF_FF0F);
        send_hdr(32'h4002);
        send_op(32'h1234);
        send_op(32'h5678);
        drain();
        check("t2_err_hdr", last_hdr[0], 32'h4801);
        check("t2_err_res", last_res[0], 32'h0);

        // Test 3: shifts in and out of range, then MAX.
        send_hdr(32'h5002);
        send_op(32'h0001);
        send_op(32'h0004);
        drain();
        check("t3_shl", last_res[0], 32'h0010);
        send_hdr(32'h5002);
        send_op(32'h0001);
        send_op(32'h0010);
        drain();
        check("t3_shl_wide16", last_res[0], 32'h0000);
        check("t3_shl_wide32", last_res[1], 32'h0001_0000);
        send_hdr(32'h8003);
        send_op(32'h0005);
        send_op(32'hA000);
        send_op(32'h0007);
        drain();
        check("t3_max", last_res[0], 32'hA000);

        // Test 4: header held under backpressure, one stray word dropped.
        bp_mode = 2;
        send_hdr(32'h0001);
        send_op(32'h0005);
        b = 0;
        forever begin
            @(negedge clk);
            if (out16.valid || b >= 20) break;
            b++;
        end
        check("t4_valid", out16.valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_hdr", {out16.cmd, out16.data}, {1'b1, 16'h0001});
            check("t4_in_ready", in16.ready, 0);
            if (i == 1) begin
                vin = 1'b1;
                din = 32'hDEAD_1234;
                cin = 1'b1;
            end
            if (i == 2) vin = 1'b0;
            @(negedge clk);
        end
        exp_drop++;
        check("t4_drop16", drop16, 1);
        check("t4_drop32", drop32, 1);
        bp_mode = 0;
        drain();
        check("t4_res", last_res[0], 32'h0005);

        // Test 5: early header aborts the partial packet.
        send_hdr(32'h0005);
        send_op(32'h1111);
        send_op(32'h2222);
        send_hdr(32'h1042);
        send_op(32'h0F0F);
        send_op(32'h00FF);
        drain();
        check("t5_abort16", abort16, 1);
        check("t5_abort32", abort32, 1);
        check("t5_hdr", last_hdr[0], 32'h1041);
        check("t5_res", last_res[0], 32'h000F);

        // Test 6: empty packet, reset mid-collect, wide operand.
        send_hdr(32'h0000);
        drain();
        check("t6_hdr", last_hdr[0], 32'h0801);
        check("t6_res", last_res[0], 32'h0);
        send_hdr(32'h0003);
        send_op(32'h0007);
        do_reset();
        repeat (10) @(negedge clk);
        check("t6_quiet", {out16.valid, out32.valid}, 0);
        send_hdr(32'h0003);
        send_op(32'hFFFF_FFFF);
        send_op(32'h0000_0002);
        send_op(32'h0000_0010);
        drain();
        check("t6_wide32", last_res[1], 32'h0000_0011);
        check("t6_wide16", last_res[0], 32'h0011);

        // Random packets with random backpressure, gaps, aborts and stray operands.
        bp_mode = 1;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) send_op($urandom);
            op = $urandom_range(0, 10);
            if (op == 4)                n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 1;
            else if (op == 5 || op == 6) n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 2;
            else                        n = $urandom_range(0, 5);
            send_hdr({16'($urandom), 4'(op), 1'b0, 5'($urandom), 6'(n)});
            nops = (n > 1 && $urandom_range(0, 11) == 0) ? n - 1 : n;
            for (int j = 0; j < nops; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if ((op == 5 || op == 6) && j == 1) opnd = 32'($urandom_range(0, 40));
                else if ($urandom_range(0, 7) == 0)  opnd = 32'hFFFF_FFFF;
                else                                 opnd = $urandom;
                send_op(opnd);
            end
        end
        drain();
        bp_mode = 0;
        check("rand_drop16", drop16, exp_drop);
        check("rand_drop32", drop32, exp_drop);
        check("rand_abort16", abort16, exp_abort);
        check("rand_abort32", abort32, exp_abort);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
